// File: rtl/bus_master_pkg.sv
// Shared bus widths, control encodings and the latched request payload.
package bus_master_pkg;

  localparam int unsigned ADDRBUS      = 10;
  localparam int unsigned DATABUS      = 16;
  localparam int unsigned BUS_READ_LAT = 1;

  localparam logic IO_CTRL_READ  = 1'b0;
  localparam logic IO_CTRL_WRITE = 1'b1;

  // Request fields captured at the CPU handshake and replayed on the bus.
  typedef struct packed {
    logic [ADDRBUS-1:0] addr;
    logic [DATABUS-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_master_if.sv
// CPU-side request/response handshake of the bus master.
interface bus_master_if;
  import bus_master_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [ADDRBUS-1:0] req_addr;
  logic [DATABUS-1:0] req_wdata;
  logic               rsp_valid;
  logic [DATABUS-1:0] rsp_rdata;
  logic               rsp_ready;

  // Requester (CPU memory stage) view.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Bus master view.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/bus_master.sv
// Bus initiator: sequences single-beat writes and multi-cycle reads on the shared device bus.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int unsigned READ_LAT = BUS_READ_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_master_if.slave        req_if,
  output logic               EN,
  output logic [ADDRBUS-1:0] addr,
  output logic               ctrl,
  inout  wire  [DATABUS-1:0] data
);

  localparam int unsigned CNT_W = ($clog2(READ_LAT + 1) > 0) ? $clog2(READ_LAT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  // A zero read latency would sample the bus before the responder can answer.
  if (READ_LAT == 0) begin : g_bad_read_lat
    $error("bus_master: READ_LAT must be at least 1");
  end

  logic [1:0]         state_q, state_d;
  bus_req_t           req_q, req_d;
  logic               ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATABUS-1:0] rdata_q, rdata_d;
  logic               data_oe;

  // State, latched request, bus control and read-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      ctrl_q  <= IO_CTRL_READ;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, request capture, latency count and read-data sampling.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          req_d.addr  = req_if.req_addr;
          req_d.wdata = req_if.req_wdata;
          cnt_d       = '0;
          if (req_if.req_we) begin
            state_d = S_WR;
            ctrl_d  = IO_CTRL_WRITE;
          end else begin
            state_d = S_RD;
            ctrl_d  = IO_CTRL_READ;
          end
        end
      end
      S_WR: begin
        state_d = S_IDLE;
      end
      S_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(READ_LAT)) begin
          rdata_d = data;
          cnt_d   = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (req_if.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and bus-enable decode of the current state.
  always_comb begin
    req_if.req_ready = 1'b0;
    req_if.rsp_valid = 1'b0;
    EN               = 1'b0;
    data_oe          = 1'b0;
    case (state_q)
      S_IDLE: req_if.req_ready = 1'b1;
      S_WR: begin
        EN      = 1'b1;
        data_oe = 1'b1;
      end
      S_RD:    EN = 1'b1;
      S_RSP:   req_if.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign addr             = req_q.addr;
  assign ctrl             = ctrl_q;
  assign req_if.rsp_rdata = rdata_q;

  // Only a write cycle drives the shared data bus.
  assign data = data_oe ? req_q.wdata : 'z;

endmodule

// File: tb/tb_bus_master.sv
// Bench: bus master against a synchronous RAM (latency 1) and a 3-cycle delayed responder.
module tb_bus_master;
  import bus_master_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with synchronous RAM responder ----------------
  bus_master_if u_if ();
  wire  [DATABUS-1:0] bus_data;
  logic               en;
  logic [ADDRBUS-1:0] addr;
  logic               ctrl;

  bus_master #(.READ_LAT(BUS_READ_LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req_if(u_if.slave),
    .EN    (en),
    .addr  (addr),
    .ctrl  (ctrl),
    .data  (bus_data)
  );

  logic [DATABUS-1:0] ram_mem [0:(1<<ADDRBUS)-1];
  logic [DATABUS-1:0] ram_q = '0;
  logic               ram_oe = 1'b0;

  always @(posedge clk) begin
    ram_oe <= en && (ctrl == IO_CTRL_READ);
    if (en && ctrl == IO_CTRL_READ)  ram_q <= ram_mem[addr];
    if (en && ctrl == IO_CTRL_WRITE) ram_mem[addr] <= bus_data;
  end
  assign bus_data = ram_oe ? ram_q : 'z;

  // ---------------- DUT with 3-cycle delayed responder ----------------
  bus_master_if u_if3 ();
  wire  [DATABUS-1:0] bus_data3;
  logic               en3;
  logic [ADDRBUS-1:0] addr3;
  logic               ctrl3;

  bus_master #(.READ_LAT(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_if(u_if3.slave),
    .EN    (en3),
    .addr  (addr3),
    .ctrl  (ctrl3),
    .data  (bus_data3)
  );

  function automatic logic [DATABUS-1:0] resp3(input logic [ADDRBUS-1:0] a);
    return {6'h2C, a} ^ 16'h0F0F;
  endfunction

  logic [2:0]         d3_p = '0;
  logic [ADDRBUS-1:0] d3_a0 = '0, d3_a1 = '0, d3_a2 = '0;
  logic               d3_oe;
  logic [DATABUS-1:0] d3_val;

  always @(posedge clk) begin
    d3_p  <= {d3_p[1:0], en3 && (ctrl3 == IO_CTRL_READ)};
    d3_a0 <= addr3;
    d3_a1 <= d3_a0;
    d3_a2 <= d3_a1;
  end
  // One cycle early it drives the inverted word, so a premature sample is visible.
  always_comb begin
    d3_oe  = d3_p[2] | d3_p[1];
    d3_val = d3_p[2] ? resp3(d3_a2) : ~resp3(d3_a1);
  end
  assign bus_data3 = d3_oe ? d3_val : 'z;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [DATABUS-1:0] shadow [0:(1<<ADDRBUS)-1];
  logic [DATABUS-1:0] exp_q [$];
  int                 rd_acc = 0;

  // Bus monitor state
  logic prev_en = 1'b0, prev_ctrl = 1'b0, prev_rsp = 1'b0;
  int   run = 0, last_run_len = 0;
  logic last_run_ctrl = 1'b0;
  int   b2b = 0, contention = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.rsp_valid && !prev_rsp)
        check_val("rsp_latency", 32'(cyc - rd_acc), 32'(BUS_READ_LAT + 1));
      if (u_if.rsp_valid && u_if.rsp_ready) begin
        if (exp_q.size() == 0) check_val("rsp_unexpected", 32'd1, 32'd0);
        else check_val("rsp_rdata", 32'(u_if.rsp_rdata), 32'(exp_q.pop_front()));
      end
      if (en && ctrl == IO_CTRL_WRITE)
        check_val("wr_bus_data", 32'(bus_data), 32'(shadow[addr]));
    end
    if (en) begin
      run <= run + 1;
      if (prev_en && ctrl != prev_ctrl) b2b <= b2b + 1;
    end else if (prev_en) begin
      last_run_len  <= run;
      last_run_ctrl <= prev_ctrl;
      run           <= 0;
    end
    if (ram_oe && en && ctrl == IO_CTRL_WRITE) contention <= contention + 1;
    prev_en   <= en;
    prev_ctrl <= ctrl;
    prev_rsp  <= u_if.rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; optionally keep req_valid high afterwards.
  task automatic do_req(input logic we, input logic [ADDRBUS-1:0] a,
                        input logic [DATABUS-1:0] wd, input logic hold);
    bit acc = 1'b0;
    u_if.req_we    = we;
    u_if.req_addr  = a;
    u_if.req_wdata = wd;
    u_if.req_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (u_if.req_ready) begin
        acc = 1'b1;
        if (we) shadow[a] = wd;
        else begin
          exp_q.push_back(shadow[a]);
          rd_acc = cyc + 1;
        end
      end
    end
    if (!acc) check_val("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) u_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    step();
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc3, rise3, en3_cnt, rsp_seen;
    logic [DATABUS-1:0] rd3;

    u_if.req_valid  = 1'b0;
    u_if.req_we     = 1'b0;
    u_if.req_addr   = '0;
    u_if.req_wdata  = '0;
    u_if.rsp_ready  = 1'b1;
    u_if3.req_valid = 1'b0;
    u_if3.req_we    = 1'b0;
    u_if3.req_addr  = '0;
    u_if3.req_wdata = '0;
    u_if3.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_en", 32'(en), 32'd0);
    check_val("rst_ctrl", 32'(ctrl), 32'(IO_CTRL_READ));
    check_val("rst_addr", 32'(addr), 32'd0);
    check_val("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", 32'(u_if.rsp_rdata), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", 32'(u_if.req_ready), 32'd1);

    // Single write: one EN cycle, ready again one cycle later
    step();
    do_req(1'b1, 10'h005, 16'hA5A5, 1'b0);
    @(negedge clk);
    check_val("wr_en", 32'(en), 32'd1);
    check_val("wr_ctrl", 32'(ctrl), 32'(IO_CTRL_WRITE));
    check_val("wr_addr", 32'(addr), 32'h005);
    check_val("wr_busy_ready", 32'(u_if.req_ready), 32'd0);
    @(negedge clk);
    check_val("wr_done_ready", 32'(u_if.req_ready), 32'd1);
    check_val("wr_done_en", 32'(en), 32'd0);
    check_val("idle_ctrl_held", 32'(ctrl), 32'(IO_CTRL_WRITE));
    @(negedge clk);
    check_val("wr_run_len", 32'(last_run_len), 32'd1);
    check_val("wr_run_ctrl", 32'(last_run_ctrl), 32'(IO_CTRL_WRITE));

    // Read back; latency checked by the monitor
    step();
    do_req(1'b0, 10'h005, 16'h0000, 1'b0);
    drain();
    check_val("rd_run_len", 32'(last_run_len), 32'(BUS_READ_LAT + 1));
    check_val("rd_run_ctrl", 32'(last_run_ctrl), 32'(IO_CTRL_READ));

    // Address range ends
    step();
    do_req(1'b1, 10'h3FF, 16'h1234, 1'b0);
    step();
    do_req(1'b1, 10'h000, 16'hFFFF, 1'b0);
    step();
    do_req(1'b0, 10'h3FF, 16'h0000, 1'b0);
    drain();
    do_req(1'b0, 10'h000, 16'h0000, 1'b0);
    drain();

    // Response back-pressure for 5 cycles
    u_if.rsp_ready = 1'b0;
    do_req(1'b0, 10'h3FF, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (u_if.rsp_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check_val("bp_rsp_valid", 32'(u_if.rsp_valid), 32'd1);
      check_val("bp_rsp_rdata", 32'(u_if.rsp_rdata), 32'h1234);
      check_val("bp_req_ready", 32'(u_if.req_ready), 32'd0);
      check_val("bp_en", 32'(en), 32'd0);
      @(negedge clk);
    end
    step();
    u_if.rsp_ready = 1'b1;
    drain();

    // Read with a write already pending behind it
    do_req(1'b0, 10'h000, 16'h0000, 1'b1);
    do_req(1'b1, 10'h010, 16'hBEEF, 1'b0);
    drain();
    repeat (3) step();
    do_req(1'b0, 10'h010, 16'h0000, 1'b0);
    drain();
    check_val("turnaround_b2b", 32'(b2b), 32'd0);

    // Reset while a read is on the bus
    step();
    do_req(1'b0, 10'h005, 16'h0000, 1'b0);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check_val("rstrd_en_before", 32'(en), 32'd1);
    @(negedge clk);
    check_val("rstrd_en", 32'(en), 32'd0);
    check_val("rstrd_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (u_if.rsp_valid) rsp_seen++;
    end
    check_val("rstrd_no_rsp", 32'(rsp_seen), 32'd0);
    check_val("rstrd_ready", 32'(u_if.req_ready), 32'd1);

    // READ_LAT = 3 against the delayed responder
    step();
    u_if3.req_we    = 1'b0;
    u_if3.req_addr  = 10'h123;
    u_if3.req_valid = 1'b1;
    acc3 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if3.req_ready) begin
        acc3 = cyc + 1;
        break;
      end
    end
    check_val("lat3_accept", 32'(u_if3.req_ready), 32'd1);
    step();
    u_if3.req_valid = 1'b0;
    en3_cnt = 0;
    rise3   = -1;
    rd3     = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en3) en3_cnt++;
      if (u_if3.rsp_valid) begin
        rise3 = cyc;
        rd3   = u_if3.rsp_rdata;
        break;
      end
    end
    check_val("lat3_en_cycles", 32'(en3_cnt), 32'd4);
    check_val("lat3_rsp_latency", 32'(rise3 - acc3), 32'd4);
    check_val("lat3_rdata", 32'(rd3), 32'(resp3(10'h123)));
    step();
    step();
    check_val("lat3_idle_en", 32'(en3), 32'd0);

    check_val("bus_contention", 32'(contention), 32'd0);
    check_val("final_b2b", 32'(b2b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
